// File: rtl/round_robin_4x1_arbiter_if.sv
// Request/grant and valid/ready bundle between four channel sources, the arbiter and its sink.
// master is the arbiter side; slave is the source/sink side.
interface round_robin_4x1_arbiter_if #(parameter int n = 4);
   logic [n-1:0] A;
   logic [n-1:0] B;
   logic [n-1:0] C;
   logic [n-1:0] D;
   logic [3:0]   req;
   logic [3:0]   gnt;
   logic [n-1:0] Y;
   logic [1:0]   S;
   logic         Y_valid;
   logic         Y_ready;

   modport master (
      input  A, B, C, D, req, Y_ready,
      output gnt, Y, S, Y_valid
   );

   modport slave (
      output A, B, C, D, req, Y_ready,
      input  gnt, Y, S, Y_valid
   );
endinterface

// File: rtl/round_robin_4x1_arbiter.sv
// Round-robin 4:1 arbiter into a one-entry output register; req -> Y/S valid next cycle.
// Backpressure: while full and not ready, gnt stays 0 and Y/S are frozen; pop+load is bubble-free.
module round_robin_4x1_arbiter #(
   parameter int n = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   round_robin_4x1_arbiter_if.master        bus
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t       state;
   state_t       state_nxt;

   logic [1:0]   last;
   logic [1:0]   cand;
   logic [1:0]   win_idx;
   logic         win_found;
   logic [n-1:0] win_dat;

   logic         pop;
   logic         can_load;
   logic         any;
   logic         load;

   logic [n-1:0] y_q;
   logic [1:0]   s_q;
   logic [3:0]   gnt_c;
   logic         valid_c;

   assign pop      = (state == FULL) & bus.Y_ready;
   assign can_load = (state == EMPTY) | pop;
   assign any      = |bus.req;
   assign load     = can_load & any & !rst;

   // Search starts one past the last winner so every requester is reached within four loads.
   always_comb begin
      cand      = '0;
      win_idx   = last;
      win_found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         cand = last + 2'(k);
         if (!win_found && bus.req[cand]) begin
            win_idx   = cand;
            win_found = 1'b1;
         end
      end
   end

   always_comb begin
      win_dat = '0;
      unique case (win_idx)
         2'd0: win_dat = bus.A;
         2'd1: win_dat = bus.B;
         2'd2: win_dat = bus.C;
         2'd3: win_dat = bus.D;
         default: win_dat = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         EMPTY: begin
            if (load) begin
               state_nxt = FULL;
            end
         end
         FULL: begin
            if (load) begin
               state_nxt = FULL;
            end else if (pop) begin
               state_nxt = EMPTY;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_comb begin
      valid_c = (state == FULL);
      gnt_c   = 4'b0000;
      if (load) begin
         gnt_c = 4'b0001 << win_idx;
      end
   end

   // last only moves on a real load, so a withdrawn request never shifts priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q  <= '0;
         s_q  <= 2'b00;
         last <= 2'b11;
      end else if (load) begin
         y_q  <= win_dat;
         s_q  <= win_idx;
         last <= win_idx;
      end
   end

   assign bus.gnt     = gnt_c;
   assign bus.Y_valid = valid_c;
   assign bus.Y       = y_q;
   assign bus.S       = s_q;

endmodule

// File: tb/tb_round_robin_4x1_arbiter.sv
// Bench for round_robin_4x1_arbiter: directed cases then random traffic against a queue-free reference model.
module tb_round_robin_4x1_arbiter;

   logic clk;
   logic rst;

   round_robin_4x1_arbiter_if #(.n(4)) bus ();

   round_robin_4x1_arbiter #(.n(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference model state
   bit       m_known = 0;
   bit       m_valid;
   int       m_last;
   int       m_y;
   int       m_s;
   int       waitc [4];

   logic [3:0] da, db, dc, dd;
   logic [3:0] g_obs;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [3:0] model_gnt(logic r, logic [3:0] rq, logic rdy);
      if (r) return 4'b0000;
      if (m_valid && !rdy) return 4'b0000;
      for (int k = 1; k <= 4; k++) begin
         int i;
         i = (m_last + k) % 4;
         if (rq[i]) return 4'(1 << i);
      end
      return 4'b0000;
   endfunction

   // One clock: drive just after negedge, check before posedge, advance the model on the edge.
   task automatic cycle(input logic r, input logic [3:0] rq, input logic rdy);
      logic [3:0] eg;
      logic [3:0] dat [4];
      rst         = r;
      bus.req     = rq;
      bus.Y_ready = rdy;
      bus.A = da; bus.B = db; bus.C = dc; bus.D = dd;
      dat[0] = da; dat[1] = db; dat[2] = dc; dat[3] = dd;
      #1;
      eg    = model_gnt(r, rq, rdy);
      g_obs = bus.gnt;
      chk("gnt", 32'(bus.gnt), 32'(eg));
      if (m_known) begin
         chk("y_valid", 32'(bus.Y_valid), 32'(m_valid));
         if (m_valid) begin
            chk("y", 32'(bus.Y), 32'(m_y));
            chk("s", 32'(bus.S), 32'(m_s));
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (r || !rq[i]) begin
            waitc[i] = 0;
         end else if (eg[i]) begin
            chk("fair", 32'(waitc[i] <= 3), 32'd1);
            waitc[i] = 0;
         end else if (eg != 4'b0000) begin
            waitc[i]++;
         end
      end
      @(posedge clk);
      if (r) begin
         m_known = 1;
         m_valid = 0;
         m_y     = 0;
         m_s     = 0;
         m_last  = 3;
      end else if (eg != 4'b0000) begin
         for (int i = 0; i < 4; i++) begin
            if (eg[i]) begin
               m_y    = int'(dat[i]);
               m_s    = i;
               m_last = i;
            end
         end
         m_valid = 1;
      end else if (m_valid && rdy) begin
         m_valid = 0;
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      bus.req = 4'b0000; bus.Y_ready = 1'b0;
      bus.A = '0; bus.B = '0; bus.C = '0; bus.D = '0;
      da = 4'h1; db = 4'h2; dc = 4'h3; dd = 4'h4;
      for (int i = 0; i < 4; i++) waitc[i] = 0;

      // reset with all channels requesting, then A,B,C,D,A
      for (int k = 0; k < 2; k++) begin
         cycle(1'b1, 4'b1111, 1'b1);
         chk("rst_gnt", 32'(g_obs), 32'd0);
      end
      chk("rst_y", 32'(bus.Y), 32'd0);
      chk("rst_s", 32'(bus.S), 32'd0);
      chk("rst_valid", 32'(bus.Y_valid), 32'd0);
      for (int k = 0; k < 5; k++) begin
         cycle(1'b0, 4'b1111, 1'b1);
         chk("rr_gnt", 32'(g_obs), 32'(1 << (k % 4)));
         chk("rr_s", 32'(bus.S), 32'(k % 4));
      end

      // single requester C
      cycle(1'b1, 4'b0000, 1'b1);
      dc = 4'hA;
      for (int k = 0; k < 4; k++) begin
         cycle(1'b0, 4'b0100, 1'b1);
         chk("single_gnt", 32'(g_obs), 32'h4);
         chk("single_y", 32'(bus.Y), 32'hA);
         chk("single_s", 32'(bus.S), 32'd2);
         chk("single_valid", 32'(bus.Y_valid), 32'd1);
      end

      // backpressure
      cycle(1'b1, 4'b0000, 1'b1);
      da = 4'h3; db = 4'h6;
      cycle(1'b0, 4'b0011, 1'b0);
      chk("bp_load", 32'(g_obs), 32'h1);
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, 4'b0011, 1'b0);
         chk("bp_gnt", 32'(g_obs), 32'h0);
         chk("bp_y", 32'(bus.Y), 32'h3);
         chk("bp_s", 32'(bus.S), 32'd0);
      end
      cycle(1'b0, 4'b0011, 1'b1);
      chk("bp_release_gnt", 32'(g_obs), 32'h2);
      chk("bp_release_s", 32'(bus.S), 32'd1);

      // wrap-around after a D grant, then back-to-back D load
      cycle(1'b1, 4'b0000, 1'b1);
      cycle(1'b0, 4'b1000, 1'b1);
      chk("wrap_d", 32'(g_obs), 32'h8);
      cycle(1'b0, 4'b1001, 1'b1);
      chk("wrap_a", 32'(g_obs), 32'h1);
      cycle(1'b0, 4'b1001, 1'b1);
      chk("wrap_d2", 32'(g_obs), 32'h8);
      dd = 4'h5;
      cycle(1'b0, 4'b1000, 1'b1);
      chk("b2b_y", 32'(bus.Y), 32'h5);
      chk("b2b_s", 32'(bus.S), 32'd3);
      chk("b2b_valid", 32'(bus.Y_valid), 32'd1);

      // mid-operation reset while full and stalled
      cycle(1'b0, 4'b0000, 1'b0);
      chk("mid_full", 32'(bus.Y_valid), 32'd1);
      cycle(1'b1, 4'b0010, 1'b0);
      chk("mid_rst_gnt", 32'(g_obs), 32'h0);
      chk("mid_valid", 32'(bus.Y_valid), 32'd0);
      chk("mid_s", 32'(bus.S), 32'd0);
      cycle(1'b0, 4'b0010, 1'b0);
      chk("mid_b_gnt", 32'(g_obs), 32'h2);

      // random traffic
      for (int k = 0; k < 800; k++) begin
         logic r;
         logic rdy;
         da = 4'($urandom); db = 4'($urandom); dc = 4'($urandom); dd = 4'($urandom);
         r   = ($urandom_range(0, 49) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         cycle(r, 4'($urandom), rdy);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
